// File: rtl/fixedp_pkg.sv
//------------------------------------------------------------------------------
// fixedp_pkg : shared types and constants for the fixed-point math units
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fixedp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic int div_iters(input int width, input int scale, input int rnd);
    return width + scale + ((rnd != 0) ? 1 : 0);
  endfunction

  function automatic int div_iter_lat(input int width, input int scale, input int rnd);
    return div_iters(width, scale, rnd) + 1;
  endfunction

  // Two's-complement extremes; callers keep the low width bits.
  function automatic logic [63:0] max_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_neg(input int width);
    return ~64'd0 << (width - 1);
  endfunction

  localparam int DIV_ITER_LAT = div_iter_lat(16, 10, 0);

endpackage

`default_nettype wire

// File: rtl/fixedp_sat.sv
//------------------------------------------------------------------------------
// fixedp_sat : sign-applies and saturates an unsigned magnitude to WIDTH bits
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fixedp_sat
  import fixedp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MW    = 26
) (
  input  logic [MW-1:0]    i_mag,
  input  logic             i_neg,
  input  logic             i_dz,
  input  logic             i_dividend_neg,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] c_POS     = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] c_NEG     = WIDTH'(min_neg(WIDTH));
  localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]    c_POS_MAG = MW'(max_pos(WIDTH));
  localparam logic [MW-1:0]    c_NEG_MAG = MW'(max_pos(WIDTH) + 64'd1);

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    if (i_dz) begin
      o_result = i_dividend_neg ? c_NEG : c_POS;
    end else if (!i_neg) begin
      if (i_mag > c_POS_MAG) begin
        o_result = c_POS;
        o_ovf    = 1'b1;
      end else begin
        o_result = i_mag[WIDTH-1:0];
      end
    end else begin
      if (i_mag > c_NEG_MAG) begin
        o_result = c_NEG;
        o_ovf    = 1'b1;
      end else begin
        // A magnitude of exactly 2^(WIDTH-1) negates onto itself, which is min_neg.
        o_result = ~i_mag[WIDTH-1:0] + c_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fixedp_div_iter.sv
//------------------------------------------------------------------------------
// fixedp_div_iter : iterative restoring signed fixed-point divider, valid/ready
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fixedp_div_iter
  import fixedp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SCALE = 10,
  parameter int ROUND = 0,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [TAGW-1:0]  out_tag,
  output logic             ovf,
  output logic             dz
);

  localparam int ITERS = div_iters(WIDTH, SCALE, ROUND);
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  div_state_e        r_state, w_next;
  logic [ITERS-1:0]  r_nq;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_dvs;
  logic              r_neg, r_dz, r_dd_neg;
  logic [TAGW-1:0]   r_tag;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_quot;
  logic [TAGW-1:0]   r_out_tag;
  logic              r_ovf, r_dz_out;

  logic [WIDTH-1:0]  w_dd_abs, w_dv_abs, w_sub, w_sat;
  logic [ITERS-1:0]  w_num, w_mag;
  logic [WIDTH:0]    w_shift;
  logic              w_ge, w_sat_ovf;

  assign w_dd_abs = dividend[WIDTH-1] ? (~dividend + c_ONE) : dividend;
  assign w_dv_abs = divisor[WIDTH-1]  ? (~divisor  + c_ONE) : divisor;

  // With rounding, one extra quotient bit below the LSB is produced for the round step.
  if (ROUND != 0) begin : g_round
    assign w_num = {w_dd_abs, {SCALE{1'b0}}, 1'b0};
    assign w_mag = {1'b0, r_nq[ITERS-1:1]} + {{(ITERS-1){1'b0}}, r_nq[0]};
  end else begin : g_trunc
    assign w_num = {w_dd_abs, {SCALE{1'b0}}};
    assign w_mag = r_nq;
  end

  // r_nq holds the unconsumed numerator bits on top and the quotient bits below.
  assign w_shift = {r_rem, r_nq[ITERS-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

  fixedp_sat #(
    .WIDTH (WIDTH),
    .MW    (ITERS)
  ) u_sat (
    .i_mag          (w_mag),
    .i_neg          (r_neg),
    .i_dz           (r_dz),
    .i_dividend_neg (r_dd_neg),
    .o_result       (w_sat),
    .o_ovf          (w_sat_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid && !abort) w_next = ST_DIV;
      ST_DIV: begin
        if (abort)                            w_next = ST_IDLE;
        else if (r_cnt == CW'(ITERS - 1))     w_next = ST_FIX;
      end
      ST_FIX:  w_next = abort ? ST_IDLE : ST_DONE;
      ST_DONE: if (abort || out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nq      <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_neg     <= 1'b0;
      r_dz      <= 1'b0;
      r_dd_neg  <= 1'b0;
      r_tag     <= '0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_out_tag <= '0;
      r_ovf     <= 1'b0;
      r_dz_out  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && !abort) begin
            r_nq     <= w_num;
            r_rem    <= '0;
            r_dvs    <= w_dv_abs;
            r_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_dz     <= (divisor == '0);
            r_dd_neg <= dividend[WIDTH-1];
            r_tag    <= in_tag;
            r_cnt    <= '0;
          end
        end
        ST_DIV: begin
          if (!abort) begin
            r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
            r_nq  <= {r_nq[ITERS-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_FIX: begin
          if (!abort) begin
            r_quot    <= w_sat;
            r_out_tag <= r_tag;
            r_ovf     <= w_sat_ovf;
            r_dz_out  <= r_dz;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign quotient  = r_quot;
  assign out_tag   = r_out_tag;
  assign ovf       = r_ovf;
  assign dz        = r_dz_out;

endmodule

`default_nettype wire

// File: tb/tb_fixedp_div_iter.sv
//------------------------------------------------------------------------------
// tb_fixedp_div_iter : directed bench for fixedp_div_iter, ROUND=0 and ROUND=1
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fixedp_div_iter;

  localparam int W    = 16;
  localparam int S    = 10;
  localparam int TW   = 4;
  localparam int LAT0 = W + S + 1;
  localparam int LAT1 = W + S + 2;

  logic          clk = 1'b0;
  logic          reset, abort, in_valid, out_ready;
  logic [W-1:0]  dividend, divisor;
  logic [TW-1:0] in_tag;

  logic          rdy0, vld0, ovf0, dz0, rdy1, vld1, ovf1, dz1;
  logic [W-1:0]  q0, q1;
  logic [TW-1:0] tag0, tag1;

  always #5 clk = ~clk;

  fixedp_div_iter #(.WIDTH(W), .SCALE(S), .ROUND(0), .TAGW(TW)) u_r0 (
    .clk(clk), .reset(reset), .abort(abort), .in_valid(in_valid), .in_ready(rdy0),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag), .out_valid(vld0),
    .out_ready(out_ready), .quotient(q0), .out_tag(tag0), .ovf(ovf0), .dz(dz0)
  );

  fixedp_div_iter #(.WIDTH(W), .SCALE(S), .ROUND(1), .TAGW(TW)) u_r1 (
    .clk(clk), .reset(reset), .abort(abort), .in_valid(in_valid), .in_ready(rdy1),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag), .out_valid(vld1),
    .out_ready(out_ready), .quotient(q1), .out_tag(tag1), .ovf(ovf1), .dz(dz1)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  bit            pend [2];
  bit            seen [2];
  int            hs   [2];
  logic [W-1:0]  eq   [2];
  logic          eovf [2];
  logic          edz  [2];
  logic [TW-1:0] etag [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact rational quotient, then truncate or round half away, then clamp.
  function automatic logic [W+1:0] model(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit rnd);
    longint sd, sv, a, b, mag, val;
    logic [W-1:0] q;
    logic o;
    if (dv == '0) return {1'b1, 1'b0, (dd[W-1] ? 16'h8000 : 16'h7FFF)};
    sd  = longint'($signed(dd));
    sv  = longint'($signed(dv));
    a   = (sd < 0) ? -sd : sd;
    b   = (sv < 0) ? -sv : sv;
    mag = rnd ? ((2 * a * (64'sd1 << S) + b) / (2 * b)) : ((a * (64'sd1 << S)) / b);
    val = ((sd < 0) != (sv < 0)) ? -mag : mag;
    o   = 1'b0;
    if (val > 32767)       begin q = 16'h7FFF; o = 1'b1; end
    else if (val < -32768) begin q = 16'h8000; o = 1'b1; end
    else                   q = val[W-1:0];
    return {1'b0, o, q};
  endfunction

  task automatic mon(input int d, input logic ir, input logic ov, input logic [W-1:0] q,
                     input logic [TW-1:0] tg, input logic of, input logic z);
    string p;
    logic [W+1:0] m;
    p = (d == 0) ? "r0" : "r1";
    if (!reset) begin
      pend[d] = 1'b0;
      return;
    end
    if (ov) begin
      chk({p, "_unexpected_valid"}, {31'b0, pend[d]}, 32'd1);
      if (pend[d]) begin
        if (!seen[d]) begin
          chk({p, "_latency"}, 32'(cyc - hs[d]), 32'((d == 0) ? LAT0 : LAT1));
          seen[d] = 1'b1;
        end
        chk({p, "_quotient"}, {16'b0, q}, {16'b0, eq[d]});
        chk({p, "_out_tag"}, {28'b0, tg}, {28'b0, etag[d]});
        chk({p, "_ovf"}, {31'b0, of}, {31'b0, eovf[d]});
        chk({p, "_dz"}, {31'b0, z}, {31'b0, edz[d]});
        chk({p, "_in_ready_busy"}, {31'b0, ir}, 32'd0);
        if (out_ready || abort) pend[d] = 1'b0;
      end
    end else if (pend[d]) begin
      chk({p, "_in_ready_busy"}, {31'b0, ir}, 32'd0);
      if (abort) pend[d] = 1'b0;
    end
    if (ir && in_valid && !abort) begin
      m       = model(dividend, divisor, d == 1);
      eq[d]   = m[W-1:0];
      eovf[d] = m[W];
      edz[d]  = m[W+1];
      etag[d] = in_tag;
      pend[d] = 1'b1;
      seen[d] = 1'b0;
      hs[d]   = cyc + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon(0, rdy0, vld0, q0, tag0, ovf0, dz0);
    mon(1, rdy1, vld1, q1, tag1, ovf1, dz1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_r0_in_ready"}, {31'b0, rdy0}, 32'd1);
    chk({name, "_r0_out_valid"}, {31'b0, vld0}, 32'd0);
    chk({name, "_r0_quotient"}, {16'b0, q0}, 32'd0);
    chk({name, "_r0_out_tag"}, {28'b0, tag0}, 32'd0);
    chk({name, "_r0_flags"}, {30'b0, ovf0, dz0}, 32'd0);
    chk({name, "_r1_in_ready"}, {31'b0, rdy1}, 32'd1);
    chk({name, "_r1_out_valid"}, {31'b0, vld1}, 32'd0);
    chk({name, "_r1_quotient"}, {16'b0, q1}, 32'd0);
    chk({name, "_r1_out_tag"}, {28'b0, tag1}, 32'd0);
    chk({name, "_r1_flags"}, {30'b0, ovf1, dz1}, 32'd0);
  endtask

  task automatic start_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic [TW-1:0] tg);
    dividend = dd;
    divisor  = dv;
    in_tag   = tg;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input logic [TW-1:0] tg, input logic [W-1:0] e0, input logic [W-1:0] e1,
                        input logic eo, input logic ez);
    bit g0, g1;
    g0 = 1'b0;
    g1 = 1'b0;
    start_op(dd, dv, tg);
    for (int i = 0; i < 60 && !(g0 && g1 && rdy0 && rdy1); i++) begin
      if (vld0 && !g0) begin
        chk({name, "_r0_lit_q"}, {16'b0, q0}, {16'b0, e0});
        chk({name, "_r0_lit_flags"}, {30'b0, ovf0, dz0}, {30'b0, eo, ez});
        g0 = 1'b1;
      end
      if (vld1 && !g1) begin
        chk({name, "_r1_lit_q"}, {16'b0, q1}, {16'b0, e1});
        chk({name, "_r1_lit_flags"}, {30'b0, ovf1, dz1}, {30'b0, eo, ez});
        g1 = 1'b1;
      end
      tick();
    end
    chk({name, "_completed"}, {30'b0, g0, g1}, 32'd3);
  endtask

  task automatic wait_valid1(input string name);
    int i;
    for (i = 0; i < 60 && !vld1; i++) tick();
    chk({name, "_valid_seen"}, {31'b0, vld1}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    abort     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    in_tag    = '0;
    #3 reset = 1'b0;
    #1 chk_reset_vals("por");
    tick();
    tick();
    reset = 1'b1;
    tick();

    run_op("three_div_two",   16'h0C00, 16'h0800, 4'd5, 16'h0600, 16'h0600, 1'b0, 1'b0);
    run_op("two_div_three",   16'h0800, 16'h0C00, 4'd5, 16'h02AA, 16'h02AB, 1'b0, 1'b0);
    run_op("ntwo_div_three",  16'hF800, 16'h0C00, 4'd5, 16'hFD56, 16'hFD55, 1'b0, 1'b0);
    run_op("big_div_lsb",     16'h7C00, 16'h0001, 4'd1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
    run_op("min_div_mone",    16'h8000, 16'hFC00, 4'd2, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
    run_op("min_div_one",     16'h8000, 16'h0400, 4'd3, 16'h8000, 16'h8000, 1'b0, 1'b0);
    run_op("neg_div_zero",    16'hFC00, 16'h0000, 4'd4, 16'h8000, 16'h8000, 1'b0, 1'b1);
    run_op("zero_div_zero",   16'h0000, 16'h0000, 4'd6, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
    run_op("zero_div_neg",    16'h0000, 16'hFC00, 4'd7, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("nlsb_div_three",  16'hFFFF, 16'h0C00, 4'd8, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("n2lsb_div_three", 16'hFFFE, 16'h0C00, 4'd9, 16'h0000, 16'hFFFF, 1'b0, 1'b0);

    // Consumer stall: result must hold while out_ready is low.
    out_ready = 1'b0;
    start_op(16'h0C00, 16'h0800, 4'd10);
    wait_valid1("stall");
    repeat (10) tick();
    out_ready = 1'b1;
    tick();
    chk("stall_r0_ready_after", {31'b0, rdy0}, 32'd1);
    chk("stall_r1_ready_after", {31'b0, rdy1}, 32'd1);

    // Abort while the result is waiting in DONE.
    out_ready = 1'b0;
    start_op(16'h0800, 16'h0C00, 4'd11);
    wait_valid1("abort_done");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b1;
    chk("abort_done_valid", {30'b0, vld0, vld1}, 32'd0);
    chk("abort_done_ready", {30'b0, rdy0, rdy1}, 32'd3);

    // Abort five cycles into the division.
    start_op(16'h0C00, 16'h0800, 4'd12);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_div_ready", {30'b0, rdy0, rdy1}, 32'd3);
    repeat (35) tick();
    chk("abort_div_no_valid", {30'b0, vld0, vld1}, 32'd0);
    run_op("after_abort", 16'h0C00, 16'h0800, 4'd5, 16'h0600, 16'h0600, 1'b0, 1'b0);

    // Abort in IDLE beats a simultaneous request.
    dividend = 16'h0C00;
    divisor  = 16'h0800;
    in_valid = 1'b1;
    abort    = 1'b1;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("abort_idle_ready", {30'b0, rdy0, rdy1}, 32'd3);
    repeat (35) tick();

    // Asynchronous reset in the middle of a division.
    start_op(16'h7C00, 16'h0001, 4'd3);
    repeat (8) tick();
    #2 reset = 1'b0;
    #1 chk_reset_vals("mid_reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    run_op("after_reset", 16'h0800, 16'h0C00, 4'd6, 16'h02AA, 16'h02AB, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fixedp_div_iter.md
Name: fixedp_div_iter

Overview:
- Iterative signed fixed-point divider with valid/ready handshake, parametrised in WIDTH/SCALE.
- Computes quotient = dividend/divisor in the same Q(WIDTH-SCALE).SCALE format as its operands.
- Adds selectable rounding, saturation with an overflow flag, divide-by-zero detection, a sideband tag and abort.
- Sits beside the multiply/sqrt units in the matrix-math datapath and feeds inverse/normalise stages.

Parameters:
- WIDTH, 16, total bits per operand/result, two's complement.
- SCALE, 10, fraction bits; 1 <= SCALE < WIDTH.
- ROUND, 0, 0 = truncate toward zero; 1 = round half away from zero.
- TAGW, 4, width of the sideband tag carried with each operation.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous cancel of the in-flight operation.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  WIDTH  signed fixed-point numerator.
- divisor  in  WIDTH  signed fixed-point denominator.
- in_tag  in  TAGW  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  WIDTH  signed fixed-point result.
- out_tag  out  TAGW  tag of this result.
- ovf  out  1  result saturated due to range.
- dz  out  1  divisor was zero.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, out_tag=0, ovf=0, dz=0, counter=0.
- ITERS = WIDTH+SCALE+ROUND.
- States: IDLE, DIV, FIX, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid&in_ready at edge k: latch |dividend|<<SCALE as a (WIDTH+SCALE+ROUND)-bit numerator, with an extra LSB 0 when ROUND=1.
  - Also latch |divisor| (WIDTH bits, unsigned; -2^(WIDTH-1) is legal), result sign = sign(dividend) XOR sign(divisor), dz = (divisor==0), and in_tag. Clear the counter and go to DIV.
- DIV:
  - One restoring-division step per cycle, MSB first: shift the remainder, trial-subtract, set the quotient bit.
  - After ITERS steps (edge k+ITERS) go to FIX.
- FIX, one cycle; sets the outputs at edge k+ITERS+1:
  - ROUND=1: magnitude = q[ITERS-1:1] + q[0].
  - ROUND=0: magnitude = q.
  - Positive sign: if magnitude > 2^(WIDTH-1)-1, quotient = 2^(WIDTH-1)-1 and ovf=1.
  - Negative sign: if magnitude > 2^(WIDTH-1), quotient = -2^(WIDTH-1) and ovf=1. Otherwise quotient = negated magnitude; zero magnitude gives 0, never a negative zero.
  - dz=1 overrides: quotient = 2^(WIDTH-1)-1 if dividend >= 0, else -2^(WIDTH-1); ovf=0.
  - Go to DONE.
- DONE:
  - quotient, out_tag, ovf and dz are held stable while out_valid=1 and out_ready=0.
  - On out_ready go to IDLE; in_ready rises on the next cycle. No back-to-back acceptance.
- Latency: in handshake edge to out_valid high = ITERS+1 cycles (27 at defaults).
- Throughput: one result per ITERS+3 cycles with out_ready tied high.
- abort:
  - In DIV or FIX: go to IDLE next edge, with no out_valid.
  - In DONE: drop the result and go to IDLE.
  - In IDLE: no effect. abort wins over a simultaneous in_valid; no operation is accepted that cycle.
- Inputs are ignored while in_ready=0.
- Reset asserted mid-operation returns everything to reset values immediately; the result is discarded.

Decomposition:
- Shared package fixedp_pkg holds:
  - the state enum (IDLE/DIV/FIX/DONE);
  - the function div_iters(WIDTH,SCALE,ROUND);
  - the max_pos(WIDTH) and min_neg(WIDTH) constants.
- Latency constant DIV_ITER_LAT = ITERS+1 is published alongside the other latency constants.
- One sub-module: fixedp_sat, purely combinational. Inputs are the magnitude, sign, dz and dividend sign. Outputs are the saturated WIDTH-bit result and the ovf flag. It is reused by other units.

Test Plan:
Defaults WIDTH=16, SCALE=10, TAG=5, out_ready=1 unless stated.
- 0x0C00 / 0x0800 (3.0/2.0) -> quotient 0x0600, ovf=0, dz=0, out_tag=5, out_valid exactly 27 cycles after the handshake.
- 0x0800 / 0x0C00 (2/3): ROUND=0 -> 0x02AA; ROUND=1 -> 0x02AB after 28 cycles. Negated dividend 0xF800: ROUND=0 -> 0xFD56; ROUND=1 -> 0xFD55.
- 0x7C00 / 0x0001 -> 0x7FFF, ovf=1. 0x8000 / 0xFC00 (-32/-1) -> 0x7FFF, ovf=1. 0x8000 / 0x0400 -> 0x8000, ovf=0.
- 0xFC00 / 0x0000 -> 0x8000, dz=1, ovf=0. 0x0000 / 0x0000 -> 0x7FFF, dz=1.
- out_ready low for 10 cycles after out_valid -> quotient/out_tag/flags stable and in_ready=0 throughout; out_ready high -> in_ready=1 on the next cycle.
- Pulse abort 5 cycles into DIV -> no out_valid; the next operation (3.0/2.0) returns 0x0600.
- Assert reset mid-DIV -> all outputs take reset values asynchronously; the next operation is correct.
